// File: rtl/dvp_pkg.sv
// -----------------------------------------------------------------------------
// dvp_pkg
// Shared definitions for the DVP transmit generator and the DVP receive
// controller: default timing, the frame FSM state encoding and a helper for
// sizing counters.
// No ports (package).
// -----------------------------------------------------------------------------
package dvp_pkg;

   // Default DVP timing (OV-style 640x480 RGB565, two bytes per pixel)
   localparam int unsigned DVP_DATA_W_DEF = 8;
   localparam int unsigned PCLK_DIV_DEF   = 6;
   localparam int unsigned HS_PRE_DEF     = 38;
   localparam int unsigned HS_LOW_DEF     = 160;
   localparam int unsigned HS_BACK_DEF    = 80;
   localparam int unsigned H_ACTIVE_DEF   = 1280;
   localparam int unsigned H_TOTAL_DEF    = 1568;
   localparam int unsigned V_SYNC_DEF     = 3;
   localparam int unsigned V_BACK_DEF     = 17;
   localparam int unsigned V_ACTIVE_DEF   = 480;
   localparam int unsigned V_FRONT_DEF    = 10;

   // Counter pattern repeats every PAT_MOD active beats
   localparam int unsigned PAT_MOD = 32;
   localparam int unsigned PAT_W   = $clog2(PAT_MOD);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_VSYNC  = 3'd1,
      ST_VBACK  = 3'd2,
      ST_LINE   = 3'd3,
      ST_VFRONT = 3'd4
   } dvp_state_e;

   // Bits needed for a counter that takes the values 0 .. n-1
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dvp_pclk_gen.sv
// -----------------------------------------------------------------------------
// dvp_pclk_gen
// Divides clk down to the DVP pixel clock and flags the clk cycle in which
// the pixel clock falls, so the frame logic can launch data that is stable
// at the following rising edge.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   i_pwdn     in   power-down: pixel clock held low, divider cleared
//   o_pclk     out  pixel clock (50 % duty, PCLK_DIV clk cycles per period)
//   o_fall_stb out  high in the clk cycle whose edge takes o_pclk 1->0
// -----------------------------------------------------------------------------
module dvp_pclk_gen
   import dvp_pkg::*;
#(
   parameter int unsigned PCLK_DIV = PCLK_DIV_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic i_pwdn,
   output logic o_pclk,
   output logic o_fall_stb
);

   localparam int unsigned HALF = PCLK_DIV / 2;
   localparam int unsigned CW   = cnt_w(HALF);

   logic [CW-1:0] r_cnt;
   logic          r_pclk;
   logic          w_term;

   assign w_term = (r_cnt == CW'(HALF - 1));

   // Counter starts at zero on reset/power-down release, so the first rising
   // edge lands HALF clk cycles later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt  <= '0;
         r_pclk <= 1'b0;
      end else if (i_pwdn) begin
         r_cnt  <= '0;
         r_pclk <= 1'b0;
      end else if (w_term) begin
         r_cnt  <= '0;
         r_pclk <= ~r_pclk;
      end else begin
         r_cnt  <= r_cnt + CW'(1);
      end
   end

   assign o_pclk     = r_pclk;
   assign o_fall_stb = w_term & r_pclk & ~i_pwdn;

endmodule

// File: rtl/dvp_tx_gen.sv
// -----------------------------------------------------------------------------
// dvp_tx_gen
// DVP (camera-style parallel video) transmit generator. Produces PCLK, VSYNC,
// HSYNC, HREF and an 8-bit byte lane framed as VSYNC / VBACK / LINE x V_ACTIVE
// / VFRONT. Active bytes come either from an internal mod-32 counter or from
// a valid/ready-style byte stream. All DVP outputs change only on PCLK falls.
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   en_i             start/continue frame generation (checked at frame ends)
//   dvp_pwdn_i       power-down: immediate IDLE, outputs and PCLK low
//   pat_sel_i        0 = counter pattern, 1 = stream (latched per frame)
//   pxl_data_i       stream byte
//   pxl_valid_i      stream byte valid
//   pxl_ready_o      one-clk strobe: stream byte taken this beat
//   dvp_pclk_o       pixel clock
//   dvp_vsync_o      frame sync
//   dvp_hsync_o      line sync
//   dvp_href_o       active-byte qualifier
//   dvp_d_o          byte lane (0 whenever href is low)
//   frame_done_o     one-clk pulse when the front porch completes
//   underrun_o       sticky: stream byte missing on an active beat
//   busy_o           FSM not in IDLE
// -----------------------------------------------------------------------------
module dvp_tx_gen
   import dvp_pkg::*;
#(
   parameter int unsigned DVP_DATA_W = DVP_DATA_W_DEF,
   parameter int unsigned PCLK_DIV   = PCLK_DIV_DEF,
   parameter int unsigned HS_PRE     = HS_PRE_DEF,
   parameter int unsigned HS_LOW     = HS_LOW_DEF,
   parameter int unsigned HS_BACK    = HS_BACK_DEF,
   parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
   parameter int unsigned H_TOTAL    = H_TOTAL_DEF,
   parameter int unsigned V_SYNC     = V_SYNC_DEF,
   parameter int unsigned V_BACK     = V_BACK_DEF,
   parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
   parameter int unsigned V_FRONT    = V_FRONT_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en_i,
   input  logic                  dvp_pwdn_i,
   input  logic                  pat_sel_i,
   input  logic [DVP_DATA_W-1:0] pxl_data_i,
   input  logic                  pxl_valid_i,
   output logic                  pxl_ready_o,
   output logic                  dvp_pclk_o,
   output logic                  dvp_vsync_o,
   output logic                  dvp_hsync_o,
   output logic                  dvp_href_o,
   output logic [DVP_DATA_W-1:0] dvp_d_o,
   output logic                  frame_done_o,
   output logic                  underrun_o,
   output logic                  busy_o
);

   // ---------------------------------------------------------------------
   // Counter sizing
   // ---------------------------------------------------------------------
   localparam int unsigned V_MAX01 = (V_SYNC   > V_BACK)  ? V_SYNC   : V_BACK;
   localparam int unsigned V_MAX23 = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
   localparam int unsigned V_MAX   = (V_MAX01  > V_MAX23) ? V_MAX01  : V_MAX23;

   localparam int unsigned HW = cnt_w(H_TOTAL);   // pclk position in a line
   localparam int unsigned VW = cnt_w(V_MAX);     // line index in a phase
   localparam int unsigned HC = HW + 1;           // headroom for window ends

   // Line windows, as half-open ranges of pclk position
   localparam logic [HC-1:0] P_LOW0 = HC'(HS_PRE);
   localparam logic [HC-1:0] P_LOW1 = HC'(HS_PRE + HS_LOW);
   localparam logic [HC-1:0] P_ACT0 = HC'(HS_PRE + HS_LOW + HS_BACK);
   localparam logic [HC-1:0] P_ACT1 = HC'(HS_PRE + HS_LOW + HS_BACK + H_ACTIVE);

   // ---------------------------------------------------------------------
   // Pixel clock
   // ---------------------------------------------------------------------
   logic w_fall;

   dvp_pclk_gen #(
      .PCLK_DIV (PCLK_DIV)
   ) u_pclk_gen (
      .clk        (clk),
      .rst        (rst),
      .i_pwdn     (dvp_pwdn_i),
      .o_pclk     (dvp_pclk_o),
      .o_fall_stb (w_fall)
   );

   // ---------------------------------------------------------------------
   // State and registered outputs
   // ---------------------------------------------------------------------
   dvp_state_e             r_state;
   logic [HW-1:0]          r_h;
   logic [VW-1:0]          r_v;
   logic [PAT_W-1:0]       r_pat;
   logic                   r_pat_sel;
   logic                   r_vsync;
   logic                   r_hsync;
   logic                   r_href;
   logic [DVP_DATA_W-1:0]  r_d;
   logic                   r_ready;
   logic                   r_frame_done;
   logic                   r_underrun;

   // ---------------------------------------------------------------------
   // Next position in the frame (applied only on a pclk fall)
   // ---------------------------------------------------------------------
   dvp_state_e             w_nxt_state;
   logic [HW-1:0]          w_nxt_h;
   logic [VW-1:0]          w_nxt_v;
   int unsigned            w_v_lim;
   logic                   w_h_last;
   logic                   w_v_last;
   logic                   w_frame_end;

   assign w_h_last = (r_h == HW'(H_TOTAL - 1));
   assign w_v_last = (r_v == VW'(w_v_lim - 1));

   always_comb begin
      case (r_state)
         ST_VSYNC: w_v_lim = V_SYNC;
         ST_VBACK: w_v_lim = V_BACK;
         ST_LINE:  w_v_lim = V_ACTIVE;
         default:  w_v_lim = V_FRONT;
      endcase
   end

   // Every non-IDLE phase is a whole number of lines: h wraps each line,
   // v counts lines within the phase, and the phase ends when both are last.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_h     = r_h;
      w_nxt_v     = r_v;
      w_frame_end = 1'b0;
      if (r_state == ST_IDLE) begin
         if (en_i) begin
            w_nxt_state = ST_VSYNC;
            w_nxt_h     = '0;
            w_nxt_v     = '0;
         end
      end else begin
         w_nxt_h = w_h_last ? '0 : r_h + HW'(1);
         if (w_h_last) begin
            if (w_v_last) begin
               w_nxt_v = '0;
               case (r_state)
                  ST_VSYNC:  w_nxt_state = ST_VBACK;
                  ST_VBACK:  w_nxt_state = ST_LINE;
                  ST_LINE:   w_nxt_state = ST_VFRONT;
                  ST_VFRONT: begin
                     w_frame_end = 1'b1;
                     w_nxt_state = en_i ? ST_VSYNC : ST_IDLE;
                  end
                  default:   w_nxt_state = ST_IDLE;
               endcase
            end else begin
               w_nxt_v = r_v + VW'(1);
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Output decode for the position being entered
   // ---------------------------------------------------------------------
   logic [HC-1:0] w_hpos;
   logic          w_in_line;
   logic          w_hs_low;
   logic          w_act;
   logic          w_vs_entry;

   assign w_hpos     = {1'b0, w_nxt_h};
   assign w_in_line  = (w_nxt_state == ST_LINE);
   assign w_hs_low   = (w_hpos >= P_LOW0) && (w_hpos < P_LOW1);
   assign w_act      = w_in_line && (w_hpos >= P_ACT0) && (w_hpos < P_ACT1);
   assign w_vs_entry = (w_nxt_state == ST_VSYNC) && (r_state != ST_VSYNC);

   // ---------------------------------------------------------------------
   // FSM, counters and data mux
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_h          <= '0;
         r_v          <= '0;
         r_pat        <= '0;
         r_pat_sel    <= 1'b0;
         r_vsync      <= 1'b0;
         r_hsync      <= 1'b0;
         r_href       <= 1'b0;
         r_d          <= '0;
         r_ready      <= 1'b0;
         r_frame_done <= 1'b0;
         r_underrun   <= 1'b0;
      end else if (dvp_pwdn_i) begin
         // Power-down abandons the frame outright; no completion pulse
         r_state      <= ST_IDLE;
         r_h          <= '0;
         r_v          <= '0;
         r_vsync      <= 1'b0;
         r_hsync      <= 1'b0;
         r_href       <= 1'b0;
         r_d          <= '0;
         r_ready      <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_ready      <= 1'b0;
         r_frame_done <= 1'b0;
         if (w_fall) begin
            r_state      <= w_nxt_state;
            r_h          <= w_nxt_h;
            r_v          <= w_nxt_v;
            r_frame_done <= w_frame_end;
            r_vsync      <= (w_nxt_state == ST_VSYNC);
            r_hsync      <= w_in_line && !w_hs_low;
            r_href       <= w_act;
            r_d          <= '0;

            if (w_vs_entry) begin
               r_pat      <= '0;
               r_underrun <= 1'b0;
               r_pat_sel  <= pat_sel_i;
            end

            // Active beats never coincide with VSYNC entry, so the source
            // latched at entry is already settled here.
            if (w_act) begin
               if (r_pat_sel) begin
                  r_ready <= 1'b1;
                  if (pxl_valid_i) begin
                     r_d <= pxl_data_i;
                  end else begin
                     r_underrun <= 1'b1;
                  end
               end else begin
                  r_d   <= DVP_DATA_W'(r_pat);
                  r_pat <= r_pat + PAT_W'(1);
               end
            end
         end
      end
   end

   assign pxl_ready_o  = r_ready;
   assign dvp_vsync_o  = r_vsync;
   assign dvp_hsync_o  = r_hsync;
   assign dvp_href_o   = r_href;
   assign dvp_d_o      = r_d;
   assign frame_done_o = r_frame_done;
   assign underrun_o   = r_underrun;
   assign busy_o       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dvp_tx_gen.sv
// -----------------------------------------------------------------------------
// tb_dvp_tx_gen
// Directed bench for dvp_tx_gen with reduced timing:
//   line = 2 pre + 3 low + 2 back + 8 active + 5 tail = 20 pclk
//   frame = 1 vsync + 1 vback + 2 active + 1 vfront lines = 100 pclk
// Counting pclk falls from VSYNC entry (fall 1): VSYNC 1..20, VBACK 21..40,
// LINE 41..80, VFRONT 81..100, frame end on fall 101.
// -----------------------------------------------------------------------------
module tb_dvp_tx_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       en_i;
   logic       dvp_pwdn_i;
   logic       pat_sel_i;
   logic [7:0] pxl_data_i;
   logic       pxl_valid_i;
   logic       pxl_ready_o;
   logic       dvp_pclk_o;
   logic       dvp_vsync_o;
   logic       dvp_hsync_o;
   logic       dvp_href_o;
   logic [7:0] dvp_d_o;
   logic       frame_done_o;
   logic       underrun_o;
   logic       busy_o;

   int n_assert = 0;
   int n_fail   = 0;
   int n_ready  = 0;
   int n_fd     = 0;

   always #5 clk = ~clk;

   dvp_tx_gen #(
      .DVP_DATA_W (8),
      .PCLK_DIV   (4),
      .HS_PRE     (2),
      .HS_LOW     (3),
      .HS_BACK    (2),
      .H_ACTIVE   (8),
      .H_TOTAL    (20),
      .V_SYNC     (1),
      .V_BACK     (1),
      .V_ACTIVE   (2),
      .V_FRONT    (1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en_i         (en_i),
      .dvp_pwdn_i   (dvp_pwdn_i),
      .pat_sel_i    (pat_sel_i),
      .pxl_data_i   (pxl_data_i),
      .pxl_valid_i  (pxl_valid_i),
      .pxl_ready_o  (pxl_ready_o),
      .dvp_pclk_o   (dvp_pclk_o),
      .dvp_vsync_o  (dvp_vsync_o),
      .dvp_hsync_o  (dvp_hsync_o),
      .dvp_href_o   (dvp_href_o),
      .dvp_d_o      (dvp_d_o),
      .frame_done_o (frame_done_o),
      .underrun_o   (underrun_o),
      .busy_o       (busy_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_pclk"},  dvp_pclk_o,   0);
      chk({tag, "_vsync"}, dvp_vsync_o,  0);
      chk({tag, "_hsync"}, dvp_hsync_o,  0);
      chk({tag, "_href"},  dvp_href_o,   0);
      chk({tag, "_d"},     dvp_d_o,      0);
      chk({tag, "_ready"}, pxl_ready_o,  0);
      chk({tag, "_fdone"}, frame_done_o, 0);
      chk({tag, "_busy"},  busy_o,       0);
   endtask

   // Advance to the negedge just after the next pclk 1->0 transition
   task automatic next_fall(output int cyc);
      logic prev;
      bit   found;
      cyc   = 0;
      found = 0;
      prev  = dvp_pclk_o;
      while (!found && cyc < 16) begin
         @(negedge clk);
         cyc++;
         if (pxl_ready_o)  n_ready++;
         if (frame_done_o) n_fd++;
         if (prev && !dvp_pclk_o) found = 1;
         prev = dvp_pclk_o;
      end
      chk("pclk_fall_seen", found, 1);
   endtask

   // Checks falls 2..101 of a frame whose VSYNC entry was just observed
   task automatic frame_body(input bit strm, input logic [7:0] base, input bit inc,
                             input int bad, input int drop_at, input bit nxt_pat);
      int         cyc, h, ln, k;
      bit         inl, act, seen_bad;
      logic [7:0] dat, exp_d;
      n_ready  = 0;
      n_fd     = 0;
      seen_bad = 0;
      for (int f = 2; f <= 101; f++) begin
         inl = (f >= 41) && (f <= 80);
         h   = inl ? (f - 41) % 20 : 0;
         ln  = inl ? (f - 41) / 20 : 0;
         act = inl && (h >= 7) && (h < 15);
         k   = act ? ln * 8 + h - 7 : -1;
         dat = inc ? base + 8'(k) : base;
         // Opposite of the latched source mid-frame; next frame's choice last
         pat_sel_i   = (f == 101) ? nxt_pat : !strm;
         pxl_valid_i = act && (k != bad);
         pxl_data_i  = dat;
         if (f == drop_at) en_i = 1'b0;
         next_fall(cyc);
         chk("pclk_period", cyc, 4);
         if (act && k == bad) seen_bad = 1;
         if (!act)           exp_d = 8'h00;
         else if (!strm)     exp_d = 8'(k % 32);
         else if (k == bad)  exp_d = 8'h00;
         else                exp_d = dat;
         chk("vsync",    dvp_vsync_o,  (f <= 20) || (f == 101 && en_i));
         chk("hsync",    dvp_hsync_o,  inl && !(h >= 2 && h < 5));
         chk("href",     dvp_href_o,   act);
         chk("data",     dvp_d_o,      exp_d);
         chk("ready",    pxl_ready_o,  strm && act);
         chk("fdone",    frame_done_o, f == 101);
         chk("busy",     busy_o,       (f < 101) || en_i);
         chk("underrun", underrun_o,   strm && seen_bad && !(f == 101 && en_i));
      end
      chk("ready_pulses_per_frame", n_ready, strm ? 16 : 0);
      chk("fdone_pulses_per_frame", n_fd, 1);
   endtask

   initial begin
      int cyc;
      rst         = 1'b1;
      en_i        = 1'b0;
      dvp_pwdn_i  = 1'b0;
      pat_sel_i   = 1'b0;
      pxl_data_i  = 8'h00;
      pxl_valid_i = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      chk("reset_underrun", underrun_o, 0);

      // First pclk rise two clk cycles after reset release
      en_i = 1'b1;
      rst  = 1'b0;
      @(negedge clk);
      chk("pclk_first_cycle", dvp_pclk_o, 0);
      @(negedge clk);
      chk("pclk_first_rise", dvp_pclk_o, 1);

      // Frame 1: counter pattern, continuous enable
      next_fall(cyc);
      chk("f1_entry_vsync", dvp_vsync_o, 1);
      chk("f1_entry_busy",  busy_o, 1);
      chk("f1_entry_href",  dvp_href_o, 0);
      frame_body(1'b0, 8'h00, 1'b0, -1, 0, 1'b1);

      // Frame 2: stream, always valid, constant 0xA5
      frame_body(1'b1, 8'hA5, 1'b0, -1, 0, 1'b1);

      // Frame 3: stream, beat 3 not valid; enable dropped mid-frame
      frame_body(1'b1, 8'h30, 1'b1, 3, 30, 1'b0);

      // Idle afterwards: no new frame without enable, underrun still held
      for (int i = 0; i < 3; i++) begin
         next_fall(cyc);
         chk("idle_vsync",    dvp_vsync_o, 0);
         chk("idle_busy",     busy_o, 0);
         chk("idle_fdone",    frame_done_o, 0);
         chk("idle_underrun", underrun_o, 1);
      end

      // Frame 4: VSYNC entry clears underrun; power down in the middle of a line
      en_i      = 1'b1;
      pat_sel_i = 1'b0;
      next_fall(cyc);
      chk("f4_entry_vsync",    dvp_vsync_o, 1);
      chk("f4_entry_underrun", underrun_o, 0);
      for (int f = 2; f <= 50; f++) next_fall(cyc);
      chk("f4_mid_href", dvp_href_o, 1);
      chk("f4_mid_data", dvp_d_o, 8'h02);
      dvp_pwdn_i = 1'b1;
      @(negedge clk);
      chk_all_zero("pwdn");
      begin
         bit pclk_seen = 0;
         repeat (6) begin
            @(negedge clk);
            if (dvp_pclk_o) pclk_seen = 1;
         end
         chk("pwdn_pclk_held_low", pclk_seen, 0);
      end

      // Release power-down with enable low: pclk runs, frame does not start
      en_i       = 1'b0;
      dvp_pwdn_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         next_fall(cyc);
         chk("release_period", cyc, 4);
         chk("release_vsync",  dvp_vsync_o, 0);
         chk("release_hsync",  dvp_hsync_o, 0);
         chk("release_busy",   busy_o, 0);
      end

      // Frame 5: restart, then asynchronous reset during an active beat
      en_i = 1'b1;
      next_fall(cyc);
      chk("f5_entry_vsync", dvp_vsync_o, 1);
      for (int f = 2; f <= 50; f++) next_fall(cyc);
      chk("f5_mid_href", dvp_href_o, 1);
      chk("f5_mid_data", dvp_d_o, 8'h02);
      #1 rst = 1'b1;
      #1;
      chk_all_zero("async_rst");
      chk("async_rst_underrun", underrun_o, 0);
      @(negedge clk);
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/dvp_tx_gen.md
DVP_TX_GEN -- requirements
Module: dvp_tx_gen

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- DVP_DATA_W, 8, byte-lane width.
- PCLK_DIV, 6, clk cycles per PCLK period; even, ≥2.
- HS_PRE, 38, PCLK cycles of HSYNC high before the HSYNC fall.
- HS_LOW, 160, PCLK cycles of HSYNC low.
- HS_BACK, 80, PCLK cycles of HSYNC high before HREF.
- H_ACTIVE, 1280, bytes per line (640 px RGB565).
- H_TOTAL, 1568, PCLK cycles per line.
- V_SYNC, 3, lines of VSYNC high.
- V_BACK, 17, lines after VSYNC.
- V_ACTIVE, 480, lines with HREF.
- V_FRONT, 10, lines after the last active line.
REQ-002 SHALL have ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock.
- rst, in, 1, reset; asynchronous, active-high.
- en_i, in, 1, frame generation enable.
- dvp_pwdn_i, in, 1, sensor power-down.
- pat_sel_i, in, 1, byte source select: 0 = counter pattern, 1 = stream.
- pxl_data_i, in, DVP_DATA_W, stream byte.
- pxl_valid_i, in, 1, stream byte valid.
- pxl_ready_o, out, 1, stream byte consumed strobe.
- dvp_pclk_o, out, 1, pixel clock.
- dvp_vsync_o, out, 1, frame sync.
- dvp_hsync_o, out, 1, line sync.
- dvp_href_o, out, 1, active-byte qualifier.
- dvp_d_o, out, DVP_DATA_W, data.
- frame_done_o, out, 1, one-cycle pulse after V_FRONT completes.
- underrun_o, out, 1, sticky stream-underrun flag.
- busy_o, out, 1, high in any state except IDLE.

Function
REQ-003 SHALL generate dvp_pclk_o by toggling every PCLK_DIV/2 clk cycles; pclk SHALL run only while dvp_pwdn_i=0 and SHALL be held low otherwise.
REQ-004 SHALL update all DVP outputs (vsync, hsync, href, d) only in the clk cycle in which dvp_pclk_o goes 1->0, so they are stable at the following rising edge.
REQ-005 SHALL implement FSM states IDLE, VSYNC, VBACK, LINE, VFRONT; each counted duration SHALL be measured in PCLK falling edges.
REQ-006 IDLE->VSYNC SHALL occur at a falling edge with en_i=1; VSYNC (vsync=1) SHALL last V_SYNC*H_TOTAL, then VBACK (vsync=0) SHALL last V_BACK*H_TOTAL, then LINE.
REQ-007 Each LINE SHALL produce, in order: hsync=1 for HS_PRE, hsync=0 for HS_LOW, hsync=1 for HS_BACK, href=1 for H_ACTIVE, then href=0 for the remainder to H_TOTAL.
REQ-008 After V_ACTIVE lines the FSM SHALL enter VFRONT for V_FRONT*H_TOTAL, then pulse frame_done_o for one clk, then go to VSYNC if en_i=1, else IDLE.
REQ-009 en_i deassertion mid-frame SHALL NOT abort the frame; the frame SHALL complete first.
REQ-010 With pat_sel_i=0, the byte on active beat k of a frame (k from 0) SHALL be k mod 32; the counter SHALL reset at each VSYNC entry.
REQ-011 With pat_sel_i=1, pxl_ready_o SHALL pulse for one clk at every active-beat update; if pxl_valid_i=1 then dvp_d_o=pxl_data_i, else dvp_d_o=0 and underrun_o SHALL set.
REQ-012 underrun_o SHALL clear on VSYNC entry; pxl_ready_o SHALL be 0 outside active beats.
REQ-013 dvp_d_o SHALL be 0 whenever href=0.
REQ-014 dvp_pwdn_i=1 at any time SHALL force IDLE within one clk, all DVP outputs 0, pclk low, and frame_done_o suppressed.
REQ-015 pat_sel_i SHALL be sampled at VSYNC entry and held for the frame.
REQ-016 Counters SHALL be sized with $clog2 of their maximum value and SHALL wrap only at their terminal counts.

Reset
REQ-017 rst=1 SHALL asynchronously force IDLE, clear all counters, and drive every output to 0.
REQ-018 After rst deasserts, the first pclk rising edge SHALL occur PCLK_DIV/2 clk cycles later, provided dvp_pwdn_i=0.

Structure
REQ-019 Timing defaults and the FSM state enum SHALL reside in package dvp_pkg, shared with dvp_rx_controller.
REQ-020 The pclk divider and edge strobes SHALL be sub-module dvp_pclk_gen; the FSM, counters and data mux SHALL be in the top module.

Verification
REQ-021 The bench SHALL use reduced parameters: H_ACTIVE=8, H_TOTAL=20, HS_PRE=2, HS_LOW=3, HS_BACK=2, V_SYNC=1, V_BACK=1, V_ACTIVE=2, V_FRONT=1, PCLK_DIV=4.
REQ-022 en_i=1, pat_sel_i=0 -> pclk period 4 clk; vsync high 20 pclk; per line, href high 8 pclk with d=0..7 then 8..15; frame_done_o after 100 pclk.
REQ-023 pat_sel_i=1, valid always 1, data=0xA5 -> 16 pxl_ready_o pulses per frame, d=0xA5 on all active beats, underrun_o=0.
REQ-024 pat_sel_i=1, valid held 0 on beat 3 -> d=0 on that beat, underrun_o=1 until the next VSYNC.
REQ-025 dvp_pwdn_i=1 mid-LINE -> next clk busy_o=0 and all outputs 0; on release, no output activity until en_i starts a new VSYNC.
REQ-026 rst pulsed mid-active -> all outputs 0 immediately (no clk edge needed); en_i dropped mid-frame -> frame completes, then IDLE.
